// File: rtl/cs_y_collector.sv
// -----------------------------------------------------------------------------
// cs_y_collector
//
// Downstream stage of the CS filter.
//
// Function
//   - Samples the Y result stream once for every cycle in which CS accepts a
//     new X.
//   - Discards the warm-up results that CS produces while its window is still
//     filling.
//   - Buffers the remaining valid results in a first-word-fall-through FIFO.
//     The FIFO drains over a valid/ready handshake.
//   - When a result arrives while the FIFO is full, the result is dropped.
//     The dropped result is recorded in a sticky overflow flag and in a
//     saturating drop counter.
//
// Ports
//   clk        rising-edge clock, shared with CS
//   reset      asynchronous, active-low (0 = reset)
//   en         CS accepted a new X this cycle; y_in is meaningful
//   y_in       CS Y result
//   restart    synchronous flush of the FIFO that also re-arms the warm-up
//   out_data   FIFO head (holds its last value while empty)
//   out_valid  FIFO not empty
//   out_ready  consumer accepts the head when out_valid=1
//   level      current occupancy, 0..DEPTH
//   overflow   sticky flag: at least one result was dropped
//   drop_cnt   number of dropped results, saturating at 255
//   clr_ovf    synchronous clear of overflow and drop_cnt
// -----------------------------------------------------------------------------
module cs_y_collector #(
   parameter int DW     = 10,
   parameter int DEPTH  = 16,
   parameter int WARMUP = 9
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic [DW-1:0]            y_in,
   input  logic                     restart,
   output logic [DW-1:0]            out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_cnt,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int WW = $clog2(WARMUP + 1);

   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
   localparam logic [WW-1:0] WARM_DONE = WW'(WARMUP);

   // Storage and state
   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [LW-1:0] level_q,    level_d;
   logic [WW-1:0] warm_cnt_q, warm_cnt_d;
   logic [DW-1:0] head_q,     head_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;

   // Handshake decode
   logic          empty;
   logic          full;
   logic          smp;
   logic          pop;
   logic          push;
   logic          drop;
   logic [AW-1:0] rd_next;

   always_comb begin
      empty   = (level_q == '0);
      full    = (level_q == FULL_LVL);
      smp     = en && (warm_cnt_q == WARM_DONE);

      // restart voids every same-cycle FIFO action
      pop     = !restart && !empty && out_ready;
      push    = !restart && smp && (!full || pop);
      drop    = !restart && smp && full && !pop;

      rd_next = rd_ptr_q + AW'(1);
   end

   // Next-state logic: pointers, occupancy and warm-up progress
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      warm_cnt_d = warm_cnt_q;

      if (restart) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         warm_cnt_d = '0;
      end else begin
         if (en && (warm_cnt_q != WARM_DONE)) begin
            warm_cnt_d = warm_cnt_q + WW'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_next;
         end
         if (push && !pop) begin
            level_d = level_q + LW'(1);
         end else if (pop && !push) begin
            level_d = level_q - LW'(1);
         end
      end
   end

   // Registered head for first-word-fall-through output.
   // - After a pop, the next head is the entry behind the current one. That
   //   entry already exists in memory when level >= 2.
   // - When level is 1, the only possible successor is the entry being pushed
   //   in the same cycle.
   // - When nothing is left, the head keeps its last value.
   always_comb begin
      head_d = head_q;
      if (pop) begin
         if (level_q > LW'(1)) begin
            head_d = mem[rd_next];
         end else if (push) begin
            head_d = y_in;
         end
      end else if (push && empty) begin
         head_d = y_in;
      end
   end

   // Overflow bookkeeping.
   // A drop that coincides with a clear restarts the count at one. This
   // ensures the drop that happens during the clear is not lost.
   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (drop && clr_ovf) begin
         overflow_d = 1'b1;
         drop_cnt_d = 8'd1;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
         drop_cnt_d = 8'd0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         warm_cnt_q <= '0;
         head_q     <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         warm_cnt_q <= warm_cnt_d;
         head_q     <= head_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // FIFO storage.
   // The storage is not reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= y_in;
      end
   end

   assign out_data  = head_q;
   assign out_valid = !empty;
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule
